bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Master-side bus interface that sits upstream of the bus arbiter: one instance per bus master, its barq_o feeding one bit of the arbiter request vector.
- Accepts single read/write commands from local logic.
- Requests the bus, waits for grant plus target ready, then drives address/data and address_valid until the arbiter's data strobe.
- Returns read data or an error status to local logic; retries after an arbiter timeout.

Parameters:
ADDR_W, 16, bus address width
DATA_W, 16, bus data width
MAX_RETRY, 3, re-attempts after arbiter error before reporting failure (0..15)
BACKOFF_CYCLES, 4, idle cycles with barq_o low between an error and the re-request (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_W  command address
cmd_wdata_i  in  DATA_W  write data
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  DATA_W  read data, valid with rsp_valid_o (0 for writes)
rsp_error_o  out  1  failed after retries, valid with rsp_valid_o
barq_o  out  1  bus request to arbiter
bagd_i  in  1  this master's grant bit from arbiter
target_ready_i  in  1  arbiter target ready
address_valid_o  out  1  address phase valid to arbiter/target
data_strobe_i  in  1  arbiter data strobe (transfer complete)
error_i  in  1  arbiter timeout error
bus_oe_o  out  1  enable for shared addr/data/we drivers
bus_addr_o  out  ADDR_W  shared bus address, 0 when not driving
bus_wdata_o  out  DATA_W  shared bus write data, 0 when not driving
bus_we_o  out  1  shared bus write flag, 0 when not driving
bus_rdata_i  in  DATA_W  shared bus read data

Behaviour:
- Reset is asynchronous and active-high. While rst=1, all outputs are 0, FSM=IDLE and the retry counter is 0. A reset in any state aborts the transaction with no rsp pulse.
- All outputs are registered; no combinational path from any input to any output.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch we/addr/wdata, clear retry_cnt, go to REQ.
  - cmd_ready_o is 0 in every other state, so only one command is outstanding.
- REQ:
  - barq_o=1.
  - When bagd_i=1 and target_ready_i=1 are sampled in the same cycle: go to ADDR.
  - error_i=1 in REQ is treated as an ADDR error (see below).
- ADDR:
  - Drives bus_oe_o=1, address_valid_o=1, bus_addr_o/bus_we_o/bus_wdata_o from the latched command.
  - barq_o stays 1.
  - Entry is registered, so address_valid_o rises one cycle after grant+ready are sampled.
- ADDR, data_strobe_i=1:
  - On that edge: barq_o, address_valid_o and bus_oe_o all go 0.
  - For a read, capture bus_rdata_i.
  - Go to RESP.
  - barq_o must drop on this edge so the arbiter does not re-latch the request after its end of cycle.
- ADDR, error_i=1, or bagd_i falls without a strobe:
  - Drop all bus outputs.
  - If retry_cnt < MAX_RETRY: increment retry_cnt, go to BACKOFF.
  - Otherwise go to RESP with the error flag set.
- Simultaneous data_strobe_i and error_i: the strobe wins and the transfer is a success.
- BACKOFF:
  - Counts BACKOFF_CYCLES cycles with barq_o=0, then returns to REQ.
  - Counter is 8 bits and loads BACKOFF_CYCLES-1 on entry.
- RESP:
  - rsp_valid_o=1 for exactly one cycle.
  - rsp_rdata_o holds captured data for a read, 0 for a write.
  - rsp_error_o = error flag, which is cleared on the return to IDLE.
  - Then IDLE.
- Minimum command-to-response latency with immediate grant: accept edge + 1 (REQ) + grant/ready wait + 1 (ADDR) + strobe wait + 1 (RESP).

Optional Feature:
- BUS_MASTER_WATCHDOG_EN
  - Defined: adds a 10-bit counter active in REQ. If bagd_i&target_ready_i has not been seen within 1023 cycles, take the error path (same retry/backoff rules).
  - Undefined: REQ waits indefinitely; no counter logic is synthesised.

Test Plan:
- Read, immediate grant, strobe 4 cycles after address_valid_o, bus_rdata_i=16'hBEEF -> one rsp_valid_o pulse, rsp_rdata_o=16'hBEEF, rsp_error_o=0; barq_o low on the strobe edge.
- Write addr=16'h0040, wdata=16'h1234 -> bus_addr_o=16'h0040, bus_wdata_o=16'h1234, bus_we_o=1 and bus_oe_o=1 only while address_valid_o=1; rsp_rdata_o=0.
- error_i on first attempt, strobe on second -> barq_o low for exactly 4 cycles, then re-request; rsp_error_o=0.
- error_i on every attempt, MAX_RETRY=3 -> 4 grants total, then a single rsp_valid_o with rsp_error_o=1; cmd_ready_o returns to 1 the next cycle.
- data_strobe_i and error_i in the same cycle -> success response, no retry.
- rst asserted mid-ADDR -> all outputs 0 immediately (asynchronous), no rsp_valid_o; a new command after rst release completes normally.

Source files
------------

// File: rtl/bus_master_port.sv
// Master-side bus port: takes one local command at a time and runs it on the shared bus.
// If BUS_MASTER_WATCHDOG_EN is defined, a stalled request is treated as a failed attempt.
module bus_master_port #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int MAX_RETRY      = 3,
    parameter int BACKOFF_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_error_o,
    output logic              barq_o,
    input  logic              bagd_i,
    input  logic              target_ready_i,
    output logic              address_valid_o,
    input  logic              data_strobe_i,
    input  logic              error_i,
    output logic              bus_oe_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic              bus_we_o,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        BACKOFF,
        RESP
    } state_t;

    localparam logic [3:0] RETRY_LIMIT  = 4'(MAX_RETRY);
    localparam logic [7:0] BACKOFF_LOAD = 8'(BACKOFF_CYCLES - 1);

    state_t            state;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        retry_cnt;
    logic [7:0]        backoff_cnt;
    logic              req_timeout;
    logic              attempt_fail;
    logic              retry_ok;

`ifdef BUS_MASTER_WATCHDOG_EN
    logic [9:0] wd_cnt;

    // Counts cycles spent in REQ; cleared whenever REQ is left so each attempt gets a full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == REQ) begin
            wd_cnt <= wd_cnt + 10'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign req_timeout = (state == REQ) && (wd_cnt == 10'd1022) && !(bagd_i && target_ready_i);
`else
    assign req_timeout = 1'b0;
`endif

    // A strobe always beats a concurrent error or grant loss in the address phase.
    always_comb begin
        attempt_fail = 1'b0;
        case (state)
            REQ:     attempt_fail = error_i || req_timeout;
            ADDR:    attempt_fail = !data_strobe_i && (error_i || !bagd_i);
            default: attempt_fail = 1'b0;
        endcase
    end

    assign retry_ok = (retry_cnt < RETRY_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cmd_we          <= 1'b0;
            cmd_addr        <= '0;
            cmd_wdata       <= '0;
            retry_cnt       <= '0;
            backoff_cnt     <= '0;
            cmd_ready_o     <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_rdata_o     <= '0;
            rsp_error_o     <= 1'b0;
            barq_o          <= 1'b0;
            address_valid_o <= 1'b0;
            bus_oe_o        <= 1'b0;
            bus_addr_o      <= '0;
            bus_wdata_o     <= '0;
            bus_we_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_we      <= cmd_we_i;
                        cmd_addr    <= cmd_addr_i;
                        cmd_wdata   <= cmd_wdata_i;
                        retry_cnt   <= '0;
                        cmd_ready_o <= 1'b0;
                        barq_o      <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bagd_i && target_ready_i) begin
                        address_valid_o <= 1'b1;
                        bus_oe_o        <= 1'b1;
                        bus_addr_o      <= cmd_addr;
                        bus_wdata_o     <= cmd_wdata;
                        bus_we_o        <= cmd_we;
                        state           <= ADDR;
                    end
                end
                ADDR: begin
                    // Request must fall on the strobe edge so the arbiter does not re-grant us.
                    if (data_strobe_i) begin
                        barq_o          <= 1'b0;
                        address_valid_o <= 1'b0;
                        bus_oe_o        <= 1'b0;
                        bus_addr_o      <= '0;
                        bus_wdata_o     <= '0;
                        bus_we_o        <= 1'b0;
                        rsp_valid_o     <= 1'b1;
                        rsp_rdata_o     <= cmd_we ? '0 : bus_rdata_i;
                        rsp_error_o     <= 1'b0;
                        state           <= RESP;
                    end
                end
                BACKOFF: begin
                    if (backoff_cnt == 8'd0) begin
                        barq_o <= 1'b1;
                        state  <= REQ;
                    end else begin
                        backoff_cnt <= backoff_cnt - 8'd1;
                    end
                end
                RESP: begin
                    rsp_valid_o <= 1'b0;
                    rsp_rdata_o <= '0;
                    rsp_error_o <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Failed attempt: release the bus, then either back off and retry or give up.
            if (attempt_fail) begin
                barq_o          <= 1'b0;
                address_valid_o <= 1'b0;
                bus_oe_o        <= 1'b0;
                bus_addr_o      <= '0;
                bus_wdata_o     <= '0;
                bus_we_o        <= 1'b0;
                if (retry_ok) begin
                    retry_cnt   <= retry_cnt + 4'd1;
                    backoff_cnt <= BACKOFF_LOAD;
                    state       <= BACKOFF;
                end else begin
                    rsp_valid_o <= 1'b1;
                    rsp_rdata_o <= '0;
                    rsp_error_o <= 1'b1;
                    state       <= RESP;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed testbench for bus_master_port: read, write, retry, exhausted retries,
// strobe/error collision and asynchronous reset during the address phase.
module tb_bus_master_port;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        barq;
    logic        bagd;
    logic        target_ready;
    logic        address_valid;
    logic        data_strobe;
    logic        error;
    logic        bus_oe;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic [15:0] bus_rdata;

    int num_checks;
    int num_errors;

    bus_master_port #(
        .ADDR_W(16),
        .DATA_W(16),
        .MAX_RETRY(3),
        .BACKOFF_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_we_i        (cmd_we),
        .cmd_addr_i      (cmd_addr),
        .cmd_wdata_i     (cmd_wdata),
        .rsp_valid_o     (rsp_valid),
        .rsp_rdata_o     (rsp_rdata),
        .rsp_error_o     (rsp_error),
        .barq_o          (barq),
        .bagd_i          (bagd),
        .target_ready_i  (target_ready),
        .address_valid_o (address_valid),
        .data_strobe_i   (data_strobe),
        .error_i         (error),
        .bus_oe_o        (bus_oe),
        .bus_addr_o      (bus_addr),
        .bus_wdata_o     (bus_wdata),
        .bus_we_o        (bus_we),
        .bus_rdata_i     (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 16'h0;
        cmd_wdata = 16'h0;
    endtask

    task automatic grant_now();
        bagd         = 1'b1;
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
    endtask

    task automatic strobe_with(input logic [15:0] rdata);
        data_strobe = 1'b1;
        bus_rdata   = rdata;
        tick();
        data_strobe = 1'b0;
        bagd        = 1'b0;
        bus_rdata   = 16'h0;
    endtask

    task automatic test_reset();
        #3;
        num_checks++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_error, barq, address_valid, bus_oe,
             bus_addr, bus_wdata, bus_we} !== 55'h0) begin
            num_errors++;
            $display("[TB] FAIL reset_outputs: got cmd_ready=%b barq=%b av=%b oe=%b rsp_valid=%b expected all 0",
                     cmd_ready, barq, address_valid, bus_oe, rsp_valid);
        end
        tick();
        tick();
        num_checks++;
        if (cmd_ready !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL reset_held_ready: got %b expected 0", cmd_ready);
        end
        rst = 1'b0;
        tick();
        num_checks++;
        if ({cmd_ready, barq} !== 2'b10) begin
            num_errors++;
            $display("[TB] FAIL reset_release_ready: got {ready,barq}=%b expected 10", {cmd_ready, barq});
        end
    endtask

    task automatic test_read();
        start_cmd(1'b0, 16'h1000, 16'h0);
        num_checks++;
        if ({cmd_ready, barq, address_valid} !== 3'b010) begin
            num_errors++;
            $display("[TB] FAIL read_req: got {ready,barq,av}=%b expected 010", {cmd_ready, barq, address_valid});
        end
        grant_now();
        num_checks++;
        if ({barq, address_valid, bus_oe, bus_we, bus_addr} !== {4'b1110, 16'h1000}) begin
            num_errors++;
            $display("[TB] FAIL read_addr_phase: got barq=%b av=%b oe=%b we=%b addr=%h expected 1 1 1 0 1000",
                     barq, address_valid, bus_oe, bus_we, bus_addr);
        end
        tick();
        tick();
        tick();
        num_checks++;
        if ({barq, address_valid} !== 2'b11) begin
            num_errors++;
            $display("[TB] FAIL read_addr_hold: got {barq,av}=%b expected 11", {barq, address_valid});
        end
        strobe_with(16'hBEEF);
        num_checks++;
        if ({barq, address_valid, bus_oe} !== 3'b000) begin
            num_errors++;
            $display("[TB] FAIL read_strobe_release: got {barq,av,oe}=%b expected 000", {barq, address_valid, bus_oe});
        end
        num_checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 16'hBEEF}) begin
            num_errors++;
            $display("[TB] FAIL read_rsp: got valid=%b err=%b rdata=%h expected 1 0 beef",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        tick();
        num_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            num_errors++;
            $display("[TB] FAIL read_rsp_single: got {rsp_valid,ready}=%b expected 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_write();
        start_cmd(1'b1, 16'h0040, 16'h1234);
        num_checks++;
        if ({bus_oe, bus_we, bus_addr, bus_wdata} !== 34'h0) begin
            num_errors++;
            $display("[TB] FAIL write_req_idle_bus: got oe=%b we=%b addr=%h wdata=%h expected all 0",
                     bus_oe, bus_we, bus_addr, bus_wdata);
        end
        grant_now();
        tick();
        num_checks++;
        if ({bus_addr, bus_wdata, bus_we, bus_oe, address_valid} !== {16'h0040, 16'h1234, 3'b111}) begin
            num_errors++;
            $display("[TB] FAIL write_addr_phase: got addr=%h wdata=%h we=%b oe=%b av=%b expected 0040 1234 1 1 1",
                     bus_addr, bus_wdata, bus_we, bus_oe, address_valid);
        end
        strobe_with(16'hFFFF);
        num_checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 16'h0000}) begin
            num_errors++;
            $display("[TB] FAIL write_rsp: got valid=%b err=%b rdata=%h expected 1 0 0000",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        num_checks++;
        if ({bus_oe, bus_we, bus_addr, bus_wdata, address_valid} !== 35'h0) begin
            num_errors++;
            $display("[TB] FAIL write_bus_release: got oe=%b we=%b addr=%h wdata=%h av=%b expected all 0",
                     bus_oe, bus_we, bus_addr, bus_wdata, address_valid);
        end
        tick();
    endtask

    task automatic test_retry();
        int low_cycles;
        start_cmd(1'b0, 16'h2000, 16'h0);
        grant_now();
        error = 1'b1;
        tick();
        error = 1'b0;
        bagd  = 1'b0;
        num_checks++;
        if ({barq, address_valid, bus_oe, rsp_valid} !== 4'b0000) begin
            num_errors++;
            $display("[TB] FAIL retry_error_release: got {barq,av,oe,rsp_valid}=%b expected 0000",
                     {barq, address_valid, bus_oe, rsp_valid});
        end
        low_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (barq === 1'b0) low_cycles++;
            else break;
            tick();
        end
        num_checks++;
        if (low_cycles != 4 || barq !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL retry_backoff: got %0d low cycles barq=%b expected 4 low then 1", low_cycles, barq);
        end
        grant_now();
        strobe_with(16'hCAFE);
        num_checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 16'hCAFE}) begin
            num_errors++;
            $display("[TB] FAIL retry_rsp: got valid=%b err=%b rdata=%h expected 1 0 cafe",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_all_errors();
        int grants;
        int waited;
        grants = 0;
        start_cmd(1'b0, 16'h3000, 16'h0);
        for (int attempt = 0; attempt < 4; attempt++) begin
            waited = 0;
            while (barq !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
            num_checks++;
            if (barq !== 1'b1) begin
                num_errors++;
                $display("[TB] FAIL all_err_rerequest: attempt %0d barq=%b expected 1 within 20 cycles", attempt, barq);
            end
            grant_now();
            if (address_valid === 1'b1) grants++;
            error = 1'b1;
            tick();
            error = 1'b0;
            bagd  = 1'b0;
            if (attempt < 3) begin
                num_checks++;
                if (rsp_valid !== 1'b0) begin
                    num_errors++;
                    $display("[TB] FAIL all_err_early_rsp: attempt %0d rsp_valid=%b expected 0", attempt, rsp_valid);
                end
            end
        end
        num_checks++;
        if (grants != 4) begin
            num_errors++;
            $display("[TB] FAIL all_err_grants: got %0d expected 4", grants);
        end
        num_checks++;
        if ({rsp_valid, rsp_error, barq, rsp_rdata} !== {3'b110, 16'h0}) begin
            num_errors++;
            $display("[TB] FAIL all_err_rsp: got valid=%b err=%b barq=%b rdata=%h expected 1 1 0 0000",
                     rsp_valid, rsp_error, barq, rsp_rdata);
        end
        tick();
        num_checks++;
        if ({rsp_valid, rsp_error, cmd_ready} !== 3'b001) begin
            num_errors++;
            $display("[TB] FAIL all_err_return_idle: got {valid,err,ready}=%b expected 001",
                     {rsp_valid, rsp_error, cmd_ready});
        end
    endtask

    task automatic test_strobe_error();
        start_cmd(1'b0, 16'h4000, 16'h0);
        grant_now();
        data_strobe = 1'b1;
        error       = 1'b1;
        bus_rdata   = 16'h5A5A;
        tick();
        data_strobe = 1'b0;
        error       = 1'b0;
        bagd        = 1'b0;
        bus_rdata   = 16'h0;
        num_checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 16'h5A5A}) begin
            num_errors++;
            $display("[TB] FAIL collide_rsp: got valid=%b err=%b rdata=%h expected 1 0 5a5a",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        tick();
        tick();
        tick();
        num_checks++;
        if ({barq, rsp_valid, cmd_ready} !== 3'b001) begin
            num_errors++;
            $display("[TB] FAIL collide_no_retry: got {barq,rsp_valid,ready}=%b expected 001",
                     {barq, rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_reset_mid_addr();
        start_cmd(1'b1, 16'h5000, 16'h7777);
        grant_now();
        num_checks++;
        if (address_valid !== 1'b1) begin
            num_errors++;
            $display("[TB] FAIL rst_mid_enter_addr: got av=%b expected 1", address_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        num_checks++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_error, barq, address_valid, bus_oe,
             bus_addr, bus_wdata, bus_we} !== 55'h0) begin
            num_errors++;
            $display("[TB] FAIL rst_mid_async: got barq=%b av=%b oe=%b addr=%h wdata=%h expected all 0",
                     barq, address_valid, bus_oe, bus_addr, bus_wdata);
        end
        bagd = 1'b0;
        tick();
        num_checks++;
        if (rsp_valid !== 1'b0) begin
            num_errors++;
            $display("[TB] FAIL rst_mid_no_rsp: got %b expected 0", rsp_valid);
        end
        rst = 1'b0;
        tick();
        num_checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            num_errors++;
            $display("[TB] FAIL rst_mid_ready: got {ready,rsp_valid}=%b expected 10", {cmd_ready, rsp_valid});
        end
        start_cmd(1'b0, 16'h6000, 16'h0);
        grant_now();
        strobe_with(16'h1357);
        num_checks++;
        if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 16'h1357}) begin
            num_errors++;
            $display("[TB] FAIL rst_mid_after: got valid=%b err=%b rdata=%h expected 1 0 1357",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        tick();
    endtask

    initial begin
        num_checks   = 0;
        num_errors   = 0;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_we       = 1'b0;
        cmd_addr     = 16'h0;
        cmd_wdata    = 16'h0;
        bagd         = 1'b0;
        target_ready = 1'b0;
        data_strobe  = 1'b0;
        error        = 1'b0;
        bus_rdata    = 16'h0;

        test_reset();
        test_read();
        test_write();
        test_retry();
        test_all_errors();
        test_strobe_error();
        test_reset_mid_addr();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete within 200000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule
